// File: rtl/uart_pkg.sv
// Shared types and helpers for the console UART output path.
// rr_grant supports up to MAX_REQ requesters.
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    localparam uart_byte_t UART_IDLE_CH = 8'h00;
    localparam int         MAX_REQ      = 32;

    // Picks the first valid requester at or after ptr, wrapping at num_req.
    // The result is one-hot, or all zero when nobody is valid.
    function automatic logic [MAX_REQ-1:0] rr_grant(
        input logic [MAX_REQ-1:0] valid,
        input int                 ptr,
        input int                 num_req
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [5:0]         idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < num_req) begin
                idx = 6'(ptr) + 6'(i);
                if (idx >= 6'(num_req)) begin
                    idx = idx - 6'(num_req);
                end
                if (!found && valid[idx[4:0]]) begin
                    grant[idx[4:0]] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush.
// The head entry is presented combinationally; there is no output register.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit separates full from empty when the indices match.
    always_comb begin
        count   = wr_ptr - rd_ptr;
        full    = (count == (AW+1)'(DEPTH));
        empty   = (wr_ptr == rd_ptr);
        do_push = push && !full && !flush;
        do_pop  = pop && !empty && !flush;
        head    = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin merge of several byte producers onto the console UART output.
// A paced drain emits one registered pulse per byte, with a programmable gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*8-1:0]          req_ch,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          flush,
    output logic                          uart_out_valid,
    output logic [7:0]                    uart_out_ch,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      winner;
    logic [NUM_REQ-1:0] grant;
    logic               push;
    uart_byte_t         push_data;
    logic               fifo_full;
    logic               fifo_empty;
    uart_byte_t         fifo_head;
    logic               fire;
    logic [GW-1:0]      gap;

    // Grants are suppressed while reset is held, so no handshake can complete then.
    always_comb begin
        grant = '0;
        if (reset && !flush && !fifo_full) begin
            grant = NUM_REQ'(rr_grant(MAX_REQ'(req_valid), int'(ptr), NUM_REQ));
        end
    end

    assign req_ready = grant;

    always_comb begin
        push      = |grant;
        winner    = '0;
        push_data = UART_IDLE_CH;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                winner    = PW'(i);
                push_data = req_ch[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (push) begin
            ptr <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // The drain only looks at occupancy from the last edge, so a fresh push is never bypassed.
    assign fire = !fifo_empty && (gap == '0) && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gap            <= '0;
            uart_out_valid <= 1'b0;
            uart_out_ch    <= UART_IDLE_CH;
        end else begin
            uart_out_valid <= fire;
            if (fire) begin
                uart_out_ch <= fifo_head;
            end
            if (flush) begin
                gap <= '0;
            end else if (fire) begin
                gap <= GAP_LOAD;
            end else if (gap != '0) begin
                gap <= gap - 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (fire),
        .flush     (flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_grant_onehot : assert property (@(posedge clock) disable iff (!reset) $onehot0(req_ready));
    a_count_bound  : assert property (@(posedge clock) disable iff (!reset)
                                      fifo_count <= ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter.
// dut_a runs with no gap; dut_b uses GAP_CYCLES=3 for the pacing, flush and mid-stream reset cases.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  a_valid, b_valid;
    logic [15:0] a_ch, b_ch;
    logic        a_flush, b_flush;
    logic [1:0]  a_ready, b_ready;
    logic        a_out_valid, b_out_valid;
    logic [7:0]  a_out_ch, b_out_ch;
    logic [3:0]  a_count, b_count;

    int total_checks = 0;
    int bad_checks   = 0;

    localparam logic [1:0]  CON_VALID [6] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
    localparam logic [15:0] CON_CH    [6] = '{16'h6141, 16'h6142, 16'h6242, 16'h6242, 16'h0000, 16'h0000};
    localparam logic [1:0]  CON_READY [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    localparam logic        CON_OUTV  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [7:0]  CON_OUTCH [6] = '{8'h00, 8'h00, 8'h41, 8'h61, 8'h42, 8'h62};

    always #5 clock = ~clock;

    uart_tx_arbiter #(.NUM_REQ(2), .FIFO_DEPTH(8), .GAP_CYCLES(0)) dut_a (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (a_valid),
        .req_ch         (a_ch),
        .req_ready      (a_ready),
        .flush          (a_flush),
        .uart_out_valid (a_out_valid),
        .uart_out_ch    (a_out_ch),
        .fifo_count     (a_count)
    );

    uart_tx_arbiter #(.NUM_REQ(2), .FIFO_DEPTH(8), .GAP_CYCLES(3)) dut_b (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (b_valid),
        .req_ch         (b_ch),
        .req_ready      (b_ready),
        .flush          (b_flush),
        .uart_out_valid (b_out_valid),
        .uart_out_ch    (b_out_ch),
        .fifo_count     (b_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit to_b, input logic [1:0] valid, input logic [15:0] ch, input logic fl);
        if (to_b) begin
            b_valid = valid;
            b_ch    = ch;
            b_flush = fl;
        end else begin
            a_valid = valid;
            a_ch    = ch;
            a_flush = fl;
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 2'b00, 16'h0000, 1'b0);
        applyStimulus(1'b1, 2'b00, 16'h0000, 1'b0);
        reset = 1'b0;
        nextCycle();
        nextCycle();
        reset = 1'b1;
        nextCycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        bad_checks++;
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

    initial begin : main
        logic [7:0] model_q [$];
        int         model_gap, next_in, pulses, last_pulse, cyc, max_count;
        logic       exp_pulse, push_now, pop_now;
        logic [7:0] exp_ch;

        reset = 1'b0;
        applyStimulus(1'b0, 2'b11, 16'h6141, 1'b0);
        applyStimulus(1'b1, 2'b11, 16'h6141, 1'b0);

        // Reset held with both requesters valid.
        for (int c = 0; c < 5; c++) begin
            nextCycle();
            checkOutput("rst_a_ready", a_ready, 2'b00);
            checkOutput("rst_a_valid", a_out_valid, 1'b0);
            checkOutput("rst_a_ch", a_out_ch, 8'h00);
            checkOutput("rst_a_count", a_count, 4'd0);
            checkOutput("rst_b_ready", b_ready, 2'b00);
            checkOutput("rst_b_count", b_count, 4'd0);
        end

        // Single byte, two-cycle latency.
        applyReset();
        applyStimulus(1'b0, 2'b01, 16'h0041, 1'b0);
        #1;
        checkOutput("single_ready", a_ready, 2'b01);
        nextCycle();
        applyStimulus(1'b0, 2'b00, 16'h0000, 1'b0);
        checkOutput("single_count_k", a_count, 4'd1);
        checkOutput("single_nobypass", a_out_valid, 1'b0);
        nextCycle();
        checkOutput("single_valid", a_out_valid, 1'b1);
        checkOutput("single_ch", a_out_ch, 8'h41);
        checkOutput("single_count_k1", a_count, 4'd0);
        nextCycle();
        checkOutput("single_pulse_end", a_out_valid, 1'b0);
        checkOutput("single_ch_hold", a_out_ch, 8'h41);

        // Contention: grants alternate A,B,A,B and bytes come out back to back.
        applyReset();
        for (int c = 0; c < 6; c++) begin
            checkOutput("con_out_valid", a_out_valid, CON_OUTV[c]);
            checkOutput("con_out_ch", a_out_ch, CON_OUTCH[c]);
            applyStimulus(1'b0, CON_VALID[c], CON_CH[c], 1'b0);
            #1;
            checkOutput("con_ready", a_ready, CON_READY[c]);
            nextCycle();
        end
        checkOutput("con_tail_valid", a_out_valid, 1'b0);
        checkOutput("con_tail_ch", a_out_ch, 8'h62);
        checkOutput("con_tail_count", a_count, 4'd0);

        // Backpressure: 16 bytes through a paced drain, checked against a small queue model.
        applyReset();
        model_gap  = 0;
        next_in    = 0;
        pulses     = 0;
        last_pulse = -1;
        cyc        = 0;
        max_count  = 0;
        exp_pulse  = 1'b0;
        exp_ch     = 8'h00;
        while (pulses < 16 && cyc < 200) begin
            checkOutput("bp_out_valid", b_out_valid, exp_pulse);
            if (exp_pulse) begin
                checkOutput("bp_out_ch", b_out_ch, exp_ch);
                if (last_pulse >= 0) begin
                    checkOutput("bp_spacing", cyc - last_pulse, 4);
                end
                last_pulse = cyc;
                pulses++;
            end
            checkOutput("bp_count", b_count, model_q.size());
            if (int'(b_count) > max_count) begin
                max_count = int'(b_count);
            end
            push_now = (next_in < 16) && (model_q.size() < 8);
            pop_now  = (model_q.size() > 0) && (model_gap == 0);
            if (next_in < 16) begin
                applyStimulus(1'b1, 2'b01, {8'h00, 8'(next_in)}, 1'b0);
            end else begin
                applyStimulus(1'b1, 2'b00, 16'h0000, 1'b0);
            end
            #1;
            checkOutput("bp_ready", b_ready, {1'b0, push_now});
            exp_pulse = pop_now;
            if (pop_now) begin
                exp_ch    = model_q.pop_front();
                model_gap = 3;
            end else if (model_gap > 0) begin
                model_gap--;
            end
            if (push_now) begin
                model_q.push_back(8'(next_in));
                next_in++;
            end
            cyc++;
            nextCycle();
        end
        checkOutput("bp_pulses", pulses, 16);
        checkOutput("bp_reached_full", max_count, 8);

        // Flush with five bytes buffered.
        applyReset();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 2'b01, {8'h00, 8'(8'h20 + i)}, 1'b0);
            nextCycle();
        end
        checkOutput("fl_count_before", b_count, 4'd5);
        applyStimulus(1'b1, 2'b01, 16'h0027, 1'b1);
        #1;
        checkOutput("fl_ready", b_ready, 2'b00);
        nextCycle();
        applyStimulus(1'b1, 2'b00, 16'h0000, 1'b0);
        checkOutput("fl_count_after", b_count, 4'd0);
        checkOutput("fl_valid_after", b_out_valid, 1'b0);
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            checkOutput("fl_no_pulse", b_out_valid, 1'b0);
            checkOutput("fl_count_idle", b_count, 4'd0);
        end

        // Asynchronous reset mid-stream, then a fresh byte from requester 0.
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b01, {8'h00, 8'(8'h10 + i)}, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 2'b00, 16'h0000, 1'b0);
        checkOutput("mid_count_before", b_count, 4'd3);
        checkOutput("mid_ch_before", b_out_ch, 8'h10);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_valid_rst", b_out_valid, 1'b0);
        checkOutput("mid_ch_rst", b_out_ch, 8'h00);
        checkOutput("mid_count_rst", b_count, 4'd0);
        #2;
        reset = 1'b1;
        nextCycle();
        applyStimulus(1'b1, 2'b11, 16'hAA55, 1'b0);
        #1;
        checkOutput("mid_ptr_zero", b_ready, 2'b01);
        nextCycle();
        applyStimulus(1'b1, 2'b00, 16'h0000, 1'b0);
        checkOutput("mid_count_k", b_count, 4'd1);
        checkOutput("mid_nobypass", b_out_valid, 1'b0);
        nextCycle();
        checkOutput("mid_valid", b_out_valid, 1'b1);
        checkOutput("mid_ch", b_out_ch, 8'h55);
        nextCycle();
        checkOutput("mid_pulse_end", b_out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
